// File: rtl/vde_timing_pkg.sv
// Shared raster timing constants and helpers for the VDE video output stage.
// Defaults describe standard 640x480@60 timing on a 25.175 MHz pixel clock.
package vde_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [23:0] DEF_UNDERRUN_RGB = 24'hFF00FF;

  // Counter widths cover the default 800 x 525 raster.
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } vde_region_t;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vde_timing_gen.sv
// Raster counters, region decode and frame-parity toggle for the video output.
// Region flags are active-high; sync polarity is applied by the output registers.
module vde_timing_gen
  import vde_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  output vde_region_t        region_o,
  output logic               frame_idx_o,
  output logic [V_CNT_W-1:0] v_cnt_o
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_BEGIN = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_BEGIN = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               frame_idx;

  // Parity flips on the first cycle of vblank, giving upstream the whole
  // blanking interval to restart before line 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_idx <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + H_CNT_W'(1);
      end
      if ((h_cnt == '0) && (v_cnt == V_ACT)) begin
        frame_idx <= ~frame_idx;
      end
    end
  end

  always_comb begin
    region_o        = '0;
    region_o.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    region_o.hsync  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    region_o.vsync  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
  end

  assign frame_idx_o = frame_idx;
  assign v_cnt_o     = v_cnt;

endmodule

// File: rtl/vde_video_out.sv
// VDE pixel pipeline sink: accepts RGB pixels in lock-step with raster timing,
// registers sync/DE/colour, and flags missing pixels through a sticky underrun bit.
module vde_video_out
  import vde_timing_pkg::*;
#(
  parameter int          H_ACTIVE     = DEF_H_ACTIVE,
  parameter int          H_FP         = DEF_H_FP,
  parameter int          H_SYNC       = DEF_H_SYNC,
  parameter int          H_BP         = DEF_H_BP,
  parameter int          V_ACTIVE     = DEF_V_ACTIVE,
  parameter int          V_FP         = DEF_V_FP,
  parameter int          V_SYNC       = DEF_V_SYNC,
  parameter int          V_BP         = DEF_V_BP,
  parameter bit          SYNC_NEG     = 1'b1,
  parameter logic [23:0] UNDERRUN_RGB = DEF_UNDERRUN_RGB
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pixel_valid_i,
  input  logic [23:0] pixel_data_i,
  output logic        pixel_ready_o,
  output logic        frame_idx_o,
  input  logic        underrun_clr_i,
  output logic        underrun_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic [9:0]  line_o
);

  vde_region_t        region;
  logic [V_CNT_W-1:0] v_cnt;
  logic               underrun_evt;

  vde_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .region_o    (region),
    .frame_idx_o (frame_idx_o),
    .v_cnt_o     (v_cnt)
  );

  // Counters sit at (0,0) during reset, so ready must also be gated by reset.
  assign pixel_ready_o = region.active & rstn_i;
  assign underrun_evt  = region.active & ~pixel_valid_i;
  assign line_o        = v_cnt;

  // A missing pixel is replaced by the marker colour; its slot is not retried.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      de_o       <= 1'b0;
      rgb_o      <= '0;
      hsync_o    <= SYNC_NEG;
      vsync_o    <= SYNC_NEG;
      underrun_o <= 1'b0;
    end else begin
      de_o    <= region.active;
      hsync_o <= region.hsync ^ SYNC_NEG;
      vsync_o <= region.vsync ^ SYNC_NEG;
      if (!region.active) begin
        rgb_o <= '0;
      end else if (pixel_valid_i) begin
        rgb_o <= pixel_data_i;
      end else begin
        rgb_o <= UNDERRUN_RGB;
      end
      if (underrun_evt) begin
        underrun_o <= 1'b1;
      end else if (underrun_clr_i) begin
        underrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vde_video_out.sv
// Bench for vde_video_out: a reduced-raster instance checked cycle by cycle
// against a timing model, plus a default 640x480 instance for throughput and reset.
module tb_vde_video_out;

  localparam int S_HA = 4, S_HFP = 1, S_HS = 2, S_HBP = 1;
  localparam int S_VA = 3, S_VFP = 1, S_VS = 1, S_VBP = 1;
  localparam int S_HT = 8, S_VT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s_n, valid_s, clr_s;
  logic [23:0] data_s;
  logic        ready_s, fidx_s, und_s, hs_s, vs_s, de_s;
  logic [23:0] rgb_s;
  logic [9:0]  line_s;

  logic        rst_d_n, valid_d, clr_d;
  logic [23:0] data_d;
  logic        ready_d, fidx_d, und_d, hs_d, vs_d, de_d;
  logic [23:0] rgb_d;
  logic [9:0]  line_d;

  vde_video_out #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_small (
    .clk_i(clk), .rstn_i(rst_s_n), .pixel_valid_i(valid_s), .pixel_data_i(data_s),
    .pixel_ready_o(ready_s), .frame_idx_o(fidx_s), .underrun_clr_i(clr_s),
    .underrun_o(und_s), .hsync_o(hs_s), .vsync_o(vs_s), .de_o(de_s),
    .rgb_o(rgb_s), .line_o(line_s)
  );

  vde_video_out dut_def (
    .clk_i(clk), .rstn_i(rst_d_n), .pixel_valid_i(valid_d), .pixel_data_i(data_d),
    .pixel_ready_o(ready_d), .frame_idx_o(fidx_d), .underrun_clr_i(clr_d),
    .underrun_o(und_d), .hsync_o(hs_d), .vsync_o(vs_d), .de_o(de_d),
    .rgb_o(rgb_d), .line_o(line_d)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        de, hs, vs, und, fidx;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    logic        valid, clr, ready, de, und;
    logic [23:0] rgb;
  } vec_t;

  exp_t        sb_q[$];
  logic [23:0] pix_q[$];
  vec_t        tbl[16];

  int mh, mv;
  bit m_fidx, m_und;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    mh = 0;
    mv = 0;
    m_fidx = 1'b0;
    m_und  = 1'b0;
    sb_q.delete();
  endtask

  // One pixel clock on the small instance: drive, predict, advance, compare.
  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic c);
    exp_t e;
    bit   act;
    valid_s = v;
    data_s  = d;
    clr_s   = c;
    act = (mh < S_HA) && (mv < S_VA);
    checkOutput("ready_s", ready_s, act);
    checkOutput("line_s", line_s, mv);
    e.de  = act;
    e.rgb = act ? (v ? d : 24'hFF00FF) : 24'h0;
    e.hs  = !((mh >= S_HA + S_HFP) && (mh < S_HA + S_HFP + S_HS));
    e.vs  = !((mv >= S_VA + S_VFP) && (mv < S_VA + S_VFP + S_VS));
    if (act && !v) m_und = 1'b1;
    else if (c)    m_und = 1'b0;
    e.und = m_und;
    if (mh == 0 && mv == S_VA) m_fidx = ~m_fidx;
    e.fidx = m_fidx;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    mh++;
    if (mh == S_HT) begin
      mh = 0;
      mv++;
      if (mv == S_VT) mv = 0;
    end
    e = sb_q.pop_front();
    checkOutput("de_s", de_s, e.de);
    checkOutput("rgb_s", rgb_s, e.rgb);
    checkOutput("hsync_s", hs_s, e.hs);
    checkOutput("vsync_s", vs_s, e.vs);
    checkOutput("underrun_s", und_s, e.und);
    checkOutput("frame_idx_s", fidx_s, e.fidx);
  endtask

  initial begin
    int pix, de_seen, hlow, vlow, dehi, rdy, tog, tog_total, idx;
    bit prev_f;
    int hsk, ddehi, dhlow, line0_rdy;

    // valid, clr, ready-before, de-after, underrun-after, rgb-after
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h100000};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h100001};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h100002};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h100003};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h100009};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h10000A};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};

    rst_s_n = 1'b1; rst_d_n = 1'b1;
    valid_s = 1'b0; data_s = '0; clr_s = 1'b0;
    valid_d = 1'b0; data_d = '0; clr_d = 1'b0;
    #1;
    rst_s_n = 1'b0;
    rst_d_n = 1'b0;
    #1;
    checkOutput("reset ready", ready_s, 0);
    checkOutput("reset de", de_s, 0);
    checkOutput("reset rgb", rgb_s, 0);
    checkOutput("reset hsync", hs_s, 1);
    checkOutput("reset vsync", vs_s, 1);
    checkOutput("reset frame_idx", fidx_s, 0);
    checkOutput("reset underrun", und_s, 0);
    checkOutput("reset line", line_s, 0);

    repeat (3) @(posedge clk);
    #3;
    rst_s_n = 1'b1;
    resetModel();
    #1;

    // Underrun / clear vectors over the first two lines of a frame.
    for (int i = 0; i < 16; i++) begin
      checkOutput("tbl ready", ready_s, tbl[i].ready);
      applyStimulus(tbl[i].valid, 24'h100000 | 24'(i), tbl[i].clr);
      checkOutput("tbl de", de_s, tbl[i].de);
      checkOutput("tbl rgb", rgb_s, tbl[i].rgb);
      checkOutput("tbl underrun", und_s, tbl[i].und);
    end
    for (int i = 16; i < S_HT * S_VT; i++) applyStimulus(1'b1, 24'h0, 1'b0);

    // Three frames of an always-valid incrementing stream.
    pix = 1;
    de_seen = 0;
    tog_total = 0;
    for (int f = 0; f < 3; f++) begin
      hlow = 0; vlow = 0; dehi = 0; rdy = 0; tog = 0;
      for (int c = 0; c < S_HT * S_VT; c++) begin
        idx = mv * S_HT + mh;
        prev_f = fidx_s;
        if (ready_s) rdy++;
        applyStimulus(1'b1, 24'(pix), 1'b0);
        if (idx % S_HT < S_HA && idx / S_HT < S_VA) pix++;
        if (!hs_s) hlow++;
        if (!vs_s) vlow++;
        if (de_s) begin
          dehi++;
          if (f == 0) begin
            de_seen++;
            checkOutput("rgb order", rgb_s, de_seen);
          end
        end
        if (fidx_s != prev_f) begin
          tog++;
          checkOutput("frame_idx toggle pos", idx, 24);
        end
      end
      checkOutput("hsync low clocks", hlow, 12);
      checkOutput("vsync low clocks", vlow, 8);
      checkOutput("de high clocks", dehi, 12);
      checkOutput("ready clocks", rdy, 12);
      checkOutput("toggles per frame", tog, 1);
      tog_total += tog;
    end
    checkOutput("toggles 3 frames", tog_total, 3);

    // Into the next frame's first line with parity at 1, then reset mid-line.
    for (int c = 0; c < S_HT * S_VT + 2; c++) applyStimulus(1'b1, 24'h00ABCD, 1'b0);
    checkOutput("pre-reset frame_idx", fidx_s, 1);
    checkOutput("pre-reset de", de_s, 1);
    #2;
    rst_s_n = 1'b0;
    #1;
    checkOutput("midreset frame_idx", fidx_s, 0);
    checkOutput("midreset de", de_s, 0);
    checkOutput("midreset rgb", rgb_s, 0);
    checkOutput("midreset ready", ready_s, 0);
    checkOutput("midreset hsync", hs_s, 1);

    // Default-timing instance: three lines with a valid, random-data upstream.
    #2;
    rst_d_n = 1'b1;
    #1;
    checkOutput("def first ready", ready_d, 1);
    checkOutput("def first line", line_d, 0);
    hsk = 0; ddehi = 0; dhlow = 0; line0_rdy = 0;
    for (int c = 0; c < 3 * 800; c++) begin
      valid_d = 1'b1;
      data_d  = 24'($urandom);
      if (ready_d && valid_d) begin
        hsk++;
        pix_q.push_back(data_d);
        if (c < 800) line0_rdy++;
      end
      @(posedge clk);
      #1;
      if (de_d) begin
        ddehi++;
        if (pix_q.size() == 0) checkOutput("def rgb no pending pixel", rgb_d, 0);
        else checkOutput("def rgb", rgb_d, pix_q.pop_front());
      end
      if (!hs_d) dhlow++;
      if (c == 799) checkOutput("def line after 800", line_d, 1);
    end
    checkOutput("def handshakes", hsk, 1920);
    checkOutput("def line0 ready", line0_rdy, 640);
    checkOutput("def de clocks", ddehi, 1920);
    checkOutput("def hsync low", dhlow, 3 * 96);
    checkOutput("def underrun", und_d, 0);
    checkOutput("def line after 2400", line_d, 3);
    checkOutput("def frame_idx", fidx_d, 0);

    repeat (100) @(posedge clk);
    #1;
    checkOutput("def pre-reset de", de_d, 1);
    #2;
    rst_d_n = 1'b0;
    #1;
    checkOutput("def midreset de", de_d, 0);
    checkOutput("def midreset rgb", rgb_d, 0);
    checkOutput("def midreset ready", ready_d, 0);
    checkOutput("def midreset frame_idx", fidx_d, 0);
    checkOutput("def midreset hsync", hs_d, 1);
    #3;
    rst_d_n = 1'b1;
    #1;
    checkOutput("def release ready", ready_d, 1);
    checkOutput("def release line", line_d, 0);
    @(posedge clk);
    #1;
    checkOutput("def release de", de_d, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vde_video_out.md
Name: vde_video_out

Overview:
- Downstream stage of the VDE pixel pipeline. Consumes the 24-bit RGB pixel stream (valid/ready) and produces raster timing: hsync, vsync, data-enable and registered RGB.
- Owns frame pacing. It generates the frame_idx toggle that the upstream emitters use to restart each frame.
- Reports pixel underruns through a sticky flag that the bus regmap can read and clear.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_NEG, 1, 1 = sync pulses active-low
- UNDERRUN_RGB, 24'hFF00FF, colour emitted when a pixel is missing

Ports:
- clk_i  in  1  pixel clock
- rstn_i  in  1  reset, asynchronous, active-low
- pixel_valid_i  in  1  upstream pixel available
- pixel_data_i  in  24  upstream pixel {R,G,B}
- pixel_ready_o  out  1  pixel accepted this cycle
- frame_idx_o  out  1  frame parity; each toggle marks a new frame start for upstream
- underrun_clr_i  in  1  clears the sticky underrun flag
- underrun_o  out  1  sticky underrun flag
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- de_o  out  1  data enable
- rgb_o  out  24  output colour
- line_o  out  10  current line counter, for status

Behaviour:
- Reset is asynchronous, active-low. On assertion:
  - h_cnt = 0, v_cnt = 0, frame_idx_o = 0, underrun_o = 0.
  - de_o = 0, rgb_o = 0, hsync_o/vsync_o at their inactive level (1 if SYNC_NEG else 0).
  - pixel_ready_o = 0.
- After deassertion, the counters start at h = 0, v = 0 (first active pixel of line 0).
- Counters:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP. V_TOTAL is defined the same way from the V_ parameters.
  - h_cnt increments every clock. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 on the same clock that h_cnt wraps.
  - Both counters are wide enough for the totals (11 bits for h, 10 bits for v at the defaults).
- Regions, derived from the counters:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync region: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync region: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Sync pulses are active-low when SYNC_NEG = 1.
- Pixel handshake:
  - pixel_ready_o = active. It is combinational from the counters and is 0 during reset.
  - Active and pixel_valid_i = 1: the pixel is transferred and pixel_data_i is captured.
  - Active and pixel_valid_i = 0: this is an underrun. UNDERRUN_RGB is emitted, underrun_o is set and the pixel slot is lost.
  - No catch-up is performed after an underrun. The upstream stream realigns at the next frame_idx toggle.
- Outputs are registered with a 1-clock latency. hsync_o, vsync_o, de_o and rgb_o all reflect the counter state of the previous cycle.
  - rgb_o = 0 whenever de_o = 0.
- frame_idx_o toggles on the clock where h_cnt = 0 and v_cnt = V_ACTIVE, i.e. the first cycle of vertical blanking.
  - This gives the upstream emitters the whole vblank to refill before line 0.
  - It toggles exactly once per frame.
- Underrun flag:
  - Set by any underrun.
  - Cleared by underrun_clr_i.
  - If a set and a clear occur in the same cycle, set wins.
- line_o = v_cnt, unregistered.
- Frame-edge boundary: the wrap at h = H_TOTAL-1, v = V_TOTAL-1 goes to (0,0) with pixel_ready_o high on the very next cycle.
- Reset asserted mid-line: the outputs go inactive immediately (asynchronous). frame_idx_o returns to 0; upstream is reset by the same rstn_i.

Decomposition:
- Shared package vde_timing_pkg holds:
  - the default 640x480 timing constants;
  - the H_TOTAL/V_TOTAL derivation functions;
  - the counter-width localparams.
- One natural sub-module, vde_timing_gen. It contains the h/v counters, region decode and frame_idx toggle, and outputs active/hsync/vsync/frame toggle.
- The top level adds the pixel handshake, the output registers and the underrun logic.

Test Plan:
- Reset release with small parameters (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1) -> h period 8, v period 6 lines. hsync low for exactly 2 clocks per line and vsync low for exactly 8 clocks per frame. de_o high for 4 clocks on lines 0..2 only, delayed 1 clock from pixel_ready_o.
- Upstream always valid, pixel data = incrementing counter from 1 -> rgb_o shows 1..12 in order across the 3 active lines with no repeats. pixel_ready_o is never high in blanking.
- frame_idx_o monitored over 3 frames -> exactly 3 toggles, each at h=0, v=V_ACTIVE (clock 24 of the frame with the small parameters).
- pixel_valid_i dropped for active pixel 5 -> rgb_o = FF00FF for that slot and underrun_o rises the following clock. Pulsing underrun_clr_i clears it. Clear and a new underrun in the same cycle -> underrun_o stays 1.
- rstn_i asserted mid-active-line at default parameters -> de_o, rgb_o and pixel_ready_o go to 0 without waiting for a clock edge and frame_idx_o goes to 0. After release, the first pixel_ready_o is seen at h=0, v=0.
- Default 640x480 run with random valid backpressure-free upstream -> 800x525 clocks per frame and 307200 handshakes per frame when no underrun occurs.
